// File: rtl/vga_sync_rx.sv
// VGA timing receiver: recovers pixel coordinates from hs/vs, validates line and
// frame periods, and emits a qualified pixel stream once timing is locked.
module vga_sync_rx #(
    parameter int DATA_W      = 9,
    parameter int H_ACTIVE    = 640,
    parameter int H_BP        = 48,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_BP        = 33,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hs,
    input  logic              vs,
    input  logic [DATA_W-1:0] pix_in,
    output logic [DATA_W-1:0] pix,
    output logic              pix_valid,
    output logic [10:0]       x,
    output logic [10:0]       y,
    output logic              frame_start,
    output logic              locked,
    output logic              sync_err,
    output logic [10:0]       h_meas,
    output logic [10:0]       v_meas
);

    localparam logic [10:0] HBP   = 11'(H_BP);
    localparam logic [10:0] H_END = 11'(H_BP + H_ACTIVE);
    localparam logic [10:0] VBP   = 11'(V_BP);
    localparam logic [10:0] V_END = 11'(V_BP + V_ACTIVE);
    localparam logic [10:0] H_TOT = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT = 11'(V_TOTAL);
    localparam logic [10:0] CMAX  = 11'h7FF;
    localparam logic [7:0]  LF    = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CMAX) ? v : v + 11'd1;
    endfunction

    logic              hs_p0, vs_p0, hs_p1, vs_p1;
    logic [DATA_W-1:0] pix_p0, pix_p1;
    logic [10:0]       hcnt, vcnt, hper, lcnt;
    logic              hs_rise, hs_fall, vs_rise, vs_fall;
    logic              line_err, frame_err, any_err, active;
    state_t            state;
    logic [7:0]        good;
    logic              err_pend;

    assign hs_rise   = hs_p0 & ~hs_p1;
    assign hs_fall   = ~hs_p0 & hs_p1;
    assign vs_rise   = vs_p0 & ~vs_p1;
    assign vs_fall   = ~vs_p0 & vs_p1;
    // A line error is either a wrong period or the period counter running out
    // with no hs fall at all; the latter is caught once on its way into saturation.
    assign line_err  = (hs_fall && hper != H_TOT) || (!hs_fall && hper == CMAX - 11'd1);
    assign frame_err = vs_fall && (lcnt != V_TOT);
    assign any_err   = line_err || frame_err;
    assign active    = (hcnt >= HBP) && (hcnt < H_END) && (vcnt >= VBP) && (vcnt < V_END);

    // input stage (_p0) and edge history (_p1); counters align with pix_p1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_p0  <= 1'b0;
            vs_p0  <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
            pix_p0 <= '0;
            pix_p1 <= '0;
            hcnt   <= '0;
            vcnt   <= '0;
            hper   <= '0;
            lcnt   <= '0;
            h_meas <= '0;
            v_meas <= '0;
        end else begin
            hs_p0  <= hs;
            vs_p0  <= vs;
            pix_p0 <= pix_in;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            pix_p1 <= pix_p0;

            hcnt <= hs_rise ? 11'd0 : sat_inc(hcnt);

            if (vs_rise)
                vcnt <= '0;
            else if (hs_rise)
                vcnt <= sat_inc(vcnt);

            if (hs_fall) begin
                h_meas <= hper;
                hper   <= 11'd1;
            end else begin
                hper <= sat_inc(hper);
            end

            // An hs fall coincident with the vs fall belongs to the new frame
            if (vs_fall) begin
                v_meas <= lcnt;
                lcnt   <= hs_fall ? 11'd1 : 11'd0;
            end else if (hs_fall) begin
                lcnt <= sat_inc(lcnt);
            end
        end
    end

    // lock FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            good     <= '0;
            err_pend <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            case (state)
                HUNT: begin
                    if (vs_fall) begin
                        state    <= CHECK;
                        good     <= '0;
                        err_pend <= 1'b0;
                    end
                end
                CHECK: begin
                    if (any_err)
                        sync_err <= 1'b1;
                    if (vs_fall) begin
                        err_pend <= 1'b0;
                        if (any_err || err_pend) begin
                            good <= '0;
                        end else begin
                            good <= good + 8'd1;
                            if (good + 8'd1 == LF) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end else if (line_err) begin
                        err_pend <= 1'b1;
                        good     <= '0;
                    end
                end
                LOCKED: begin
                    if (any_err) begin
                        sync_err <= 1'b1;
                        locked   <= 1'b0;
                        state    <= HUNT;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

    // output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix         <= '0;
            x           <= '0;
            y           <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= active && (state == LOCKED);
            frame_start <= active && (state == LOCKED) && (hcnt == HBP) && (vcnt == VBP);
            if (active && (state == LOCKED)) begin
                pix <= pix_p1;
                x   <= hcnt - HBP;
                y   <= vcnt - VBP;
            end
        end
    end

endmodule
